// File: rtl/mont_mul_sequencer.sv
// Sequencer for one multiply-then-reduce operation: it registers an operand pair, forms the
// full signed product, starts an external Montgomery reducer and hands back its result.
module mont_mul_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_a,
    input  logic [15:0] s_b,
    output logic        red_ce,
    output logic [31:0] red_a,
    input  logic        red_done,
    input  logic [15:0] red_coeff,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] m_coeff,
    output logic        err,
    output logic [7:0]  done_cnt
);
    localparam int CW = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_MUL    = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_OUT    = 3'd4;

    logic [2:0]         state;
    logic signed [15:0] a_q, b_q;
    logic signed [31:0] prod;
    logic [CW-1:0]      wait_cnt;

    // Both operands signed, so the multiply is a full signed 16x16 -> 32.
    assign prod    = a_q * b_q;
    assign s_ready = (state == S_IDLE);
    assign m_valid = (state == S_OUT);
    assign red_ce  = (state == S_LAUNCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            red_a    <= '0;
            m_coeff  <= '0;
            err      <= 1'b0;
            done_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (s_valid) begin
                        a_q   <= s_a;
                        b_q   <= s_b;
                        state <= S_MUL;
                    end
                end
                S_MUL: begin
                    // red_a is written only here; the reducer re-reads it near completion.
                    red_a <= prod;
                    state <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (red_done) begin
                        m_coeff <= red_coeff;
                        state   <= S_OUT;
                    end else if (wait_cnt == WAIT_LAST) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    if (m_ready) begin
                        done_cnt <= done_cnt + 8'd1;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mont_mul_sequencer.sv
// Directed bench for mont_mul_sequencer with a 5-cycle behavioural reducer and an
// expected-result queue filled at drive time and drained when m_valid appears.
module tb_mont_mul_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_a = '0;
    logic [15:0] s_b = '0;
    logic        red_ce;
    logic [31:0] red_a;
    logic        red_done = 1'b0;
    logic [15:0] red_coeff = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] m_coeff;
    logic        err;
    logic [7:0]  done_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // Reducer model controls
    bit          red_respond = 1'b1;
    bit          chk_red_a   = 1'b1;
    int          red_busy    = 0;
    logic [31:0] red_cap     = '0;
    int          ce_count    = 0;

    logic [31:0] exp_prod_q[$];
    logic [15:0] exp_coeff_q[$];
    logic [7:0]  exp_done = 8'd0;

    mont_mul_sequencer #(.TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .red_ce(red_ce), .red_a(red_a), .red_done(red_done), .red_coeff(red_coeff),
        .m_valid(m_valid), .m_ready(m_ready), .m_coeff(m_coeff),
        .err(err), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] fred(input logic signed [31:0] x);
        int r;
        r = x % 3329;
        if (r < 0) r += 3329;
        return 16'(r);
    endfunction

    // Behavioural reducer: result 5 cycles after red_ce, computed from red_a as read at completion.
    always @(negedge clk) begin
        if (red_ce) begin
            red_busy <= 5;
            red_cap  <= red_a;
            ce_count <= ce_count + 1;
        end else if (red_busy != 0) begin
            red_busy <= red_busy - 1;
        end
        red_done  <= (red_busy == 1) && red_respond;
        red_coeff <= fred(red_a);
        if (red_busy == 1 && chk_red_a)
            chk("red_a_stable", red_a, red_cap);
    end

    task automatic accept(input logic [15:0] a, input logic [15:0] b);
        int t;
        @(negedge clk);
        s_a = a; s_b = b; s_valid = 1'b1;
        t = 0;
        while (!s_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("accept_ready", 32'(s_ready), 32'd1);
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int hold);
        int i, nce, ce_at;
        logic [31:0] ep;
        logic [15:0] ec;
        ep = 32'($signed(a) * $signed(b));
        exp_prod_q.push_back(ep);
        exp_coeff_q.push_back(fred(ep));
        accept(a, b);
        nce = 0; ce_at = 0;
        for (i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) s_valid = 1'b0;
            if (red_ce) begin nce++; ce_at = i; end
            if (m_valid) break;
        end
        chk("mvalid_latency", 32'(i), 32'd8);
        chk("red_ce_at", 32'(ce_at), 32'd2);
        chk("red_ce_pulses", 32'(nce), 32'd1);
        ep = exp_prod_q.pop_front();
        ec = exp_coeff_q.pop_front();
        chk("red_a", red_a, ep);
        chk("m_coeff", 32'(m_coeff), 32'(ec));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_mvalid", 32'(m_valid), 32'd1);
            chk("hold_mcoeff", 32'(m_coeff), 32'(ec));
            chk("hold_sready", 32'(s_ready), 32'd0);
            chk("hold_done_cnt", 32'(done_cnt), 32'(exp_done));
        end
        chk("out_sready", 32'(s_ready), 32'd0);
        m_ready = 1'b1;
        exp_done = exp_done + 8'd1;
        @(negedge clk);
        m_ready = 1'b0;
        chk("post_mvalid", 32'(m_valid), 32'd0);
        chk("post_sready", 32'(s_ready), 32'd1);
        chk("done_cnt", 32'(done_cnt), 32'(exp_done));
    endtask

    initial begin
        int ce0;
        bit saw_mv;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_red_ce", 32'(red_ce), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_done_cnt", 32'(done_cnt), 32'd0);
        chk("rst_red_a", red_a, 32'd0);
        chk("rst_m_coeff", 32'(m_coeff), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        rst_n = 1'b1;

        // Basic operation and product corner cases
        do_op(16'd3329, 16'd1, 0);
        do_op(16'hFFFF, 16'hFFFF, 0);
        do_op(16'h8000, 16'h8000, 0);
        do_op(16'h8000, 16'h7FFF, 0);
        chk("prod_neg_max", 32'($signed(16'sh8000) * $signed(16'sh7FFF)), 32'hC0008000);

        // Output back-pressure
        do_op(16'd1234, 16'hFDC9, 10);

        // Reducer never answers: 16 WAIT cycles then err and back to IDLE
        red_respond = 1'b0;
        accept(16'd7, 16'd9);
        saw_mv = 1'b0;
        for (int i = 1; i <= 19; i++) begin
            @(negedge clk);
            if (i == 1) s_valid = 1'b0;
            if (m_valid) saw_mv = 1'b1;
            if (i == 18) begin
                chk("to_err_before", 32'(err), 32'd0);
                chk("to_sready_before", 32'(s_ready), 32'd0);
            end
        end
        chk("to_err", 32'(err), 32'd1);
        chk("to_idle", 32'(s_ready), 32'd1);
        chk("to_no_mvalid", 32'(saw_mv), 32'd0);
        chk("to_done_cnt", 32'(done_cnt), 32'(exp_done));
        red_respond = 1'b1;
        repeat (6) @(negedge clk);
        do_op(16'd100, 16'd200, 0);
        chk("to_err_sticky", 32'(err), 32'd1);

        // Reset in the middle of WAIT, reducer answers afterwards
        accept(16'd55, 16'd66);
        @(negedge clk);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_red_a = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_mvalid", 32'(m_valid), 32'd0);
        chk("abort_red_a", red_a, 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_done = 8'd0;
        saw_mv = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (m_valid) saw_mv = 1'b1;
        end
        chk("abort_no_mvalid", 32'(saw_mv), 32'd0);
        chk("abort_done_cnt", 32'(done_cnt), 32'd0);
        chk("abort_err_after", 32'(err), 32'd0);
        chk_red_a = 1'b1;

        // 256 operations: done_cnt wraps back to 0, one red_ce each
        ce0 = ce_count;
        for (int n = 0; n < 256; n++)
            do_op(16'($urandom), 16'($urandom), 0);
        @(negedge clk);
        chk("wrap_done_cnt", 32'(done_cnt), 32'd0);
        chk("wrap_ce_count", 32'(ce_count - ce0), 32'd256);
        chk("wrap_err", 32'(err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
